bm_sig_sim: RTL and testbench

- Word-parallel simulation engine for the 4-input / 2-output boolean-matching function pair.
  - y0 = x0 & x1
  - y1 = (x2 & x0) | (x1 & (~x0 | x3))
- Each lane evaluates one input pattern, so W patterns are processed per word.
- Over a batch of words, accumulates per-output ones-count signatures for the matcher's signature-comparison stage.
- Sits between the random-pattern source and the signature comparator; valid/ready on input and word output.

---
 rtl/bm_sim_pkg.sv | 35 +++
 rtl/bm_popcount.sv | 19 +
 rtl/bm_sig_sim.sv | 141 ++++++++++++++
 tb/tb_bm_sig_sim.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bm_sim_pkg.sv
// Shared definitions for the boolean-matching simulation engine:
// default geometry, the per-lane output functions and the signature width rule.
package bm_sim_pkg;

  localparam int BM_W_DEF     = 32;
  localparam int BM_BATCH_DEF = 16;

  // Widest word the evaluation functions handle. Callers zero-extend to this
  // width and cast the result back down to their own W.
  localparam int BM_MAX_W = 1024;

  // y0 = x0 & x1, evaluated lane by lane.
  function automatic logic [BM_MAX_W-1:0] bm_eval_y0(
    input logic [BM_MAX_W-1:0] x0,
    input logic [BM_MAX_W-1:0] x1
  );
    return x0 & x1;
  endfunction

  // y1 = (x2 & x0) | (x1 & (~x0 | x3)), evaluated lane by lane.
  function automatic logic [BM_MAX_W-1:0] bm_eval_y1(
    input logic [BM_MAX_W-1:0] x0,
    input logic [BM_MAX_W-1:0] x1,
    input logic [BM_MAX_W-1:0] x2,
    input logic [BM_MAX_W-1:0] x3
  );
    return (x2 & x0) | (x1 & (~x0 | x3));
  endfunction

  // A batch can hold at most w*batch ones, so the count needs room for that value.
  function automatic int bm_cnt_w(input int w, input int batch);
    return $clog2(w * batch + 1);
  endfunction

endpackage

// File: rtl/bm_popcount.sv
// Combinational ones counter over a W-bit word.
module bm_popcount #(
  parameter int W = 32
) (
  input  logic [W-1:0]             din,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int PC_W = $clog2(W+1);

  // Sum every lane; the synthesiser turns this into an adder tree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + PC_W'(din[i]);
    end
  end

endmodule

// File: rtl/bm_sig_sim.sv
// Word-parallel simulator for the y0/y1 matching pair with per-batch ones-count
// signatures. Optional rotate-xor hash signatures when BM_SIG_HASH_EN is defined.
module bm_sig_sim
  import bm_sim_pkg::*;
#(
  parameter  int W     = BM_W_DEF,
  parameter  int BATCH = BM_BATCH_DEF,
  localparam int CNT_W = bm_cnt_w(W, BATCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x0,
  input  logic [W-1:0]     in_x1,
  input  logic [W-1:0]     in_x2,
  input  logic [W-1:0]     in_x3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y0,
  output logic [W-1:0]     out_y1,
`ifdef BM_SIG_HASH_EN
  output logic [W-1:0]     sig_y0_hash,
  output logic [W-1:0]     sig_y1_hash,
`endif
  output logic             sig_valid,
  output logic [CNT_W-1:0] sig_y0_ones,
  output logic [CNT_W-1:0] sig_y1_ones
);

  localparam int PC_W = $clog2(W+1);
  localparam int WC_W = (BATCH > 1) ? $clog2(BATCH) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(BATCH-1);

  logic [W-1:0]     y0_w, y1_w;
  logic [PC_W-1:0]  pc0, pc1;
  logic             accept, last;
  logic [CNT_W-1:0] acc0, acc1, acc0_base, acc1_base, acc0_nxt, acc1_nxt;
  logic [WC_W-1:0]  wcnt, wcnt_base;

  assign y0_w = W'(bm_eval_y0(BM_MAX_W'(in_x0), BM_MAX_W'(in_x1)));
  assign y1_w = W'(bm_eval_y1(BM_MAX_W'(in_x0), BM_MAX_W'(in_x1),
                              BM_MAX_W'(in_x2), BM_MAX_W'(in_x3)));

  bm_popcount #(.W(W)) u_pc0 (.din(y0_w), .cnt(pc0));
  bm_popcount #(.W(W)) u_pc1 (.din(y1_w), .cnt(pc1));

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // clear takes effect before the same-cycle word is counted, so that word
  // opens the new batch instead of finishing the aborted one.
  always_comb begin
    acc0_base = clear ? '0 : acc0;
    acc1_base = clear ? '0 : acc1;
    wcnt_base = clear ? '0 : wcnt;
    acc0_nxt  = acc0_base + CNT_W'(pc0);
    acc1_nxt  = acc1_base + CNT_W'(pc1);
    last      = accept && (wcnt_base == WC_LAST);
  end

  // Output word register: load on accept, hold under backpressure, drop when drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y0    <= '0;
      out_y1    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_y0    <= y0_w;
      out_y1    <= y1_w;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Batch accumulation and signature publish; counters restart on the closing word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc0        <= '0;
      acc1        <= '0;
      wcnt        <= '0;
      sig_valid   <= 1'b0;
      sig_y0_ones <= '0;
      sig_y1_ones <= '0;
    end else begin
      sig_valid <= 1'b0;
      if (last) begin
        sig_valid   <= 1'b1;
        sig_y0_ones <= acc0_nxt;
        sig_y1_ones <= acc1_nxt;
        acc0        <= '0;
        acc1        <= '0;
        wcnt        <= '0;
      end else if (accept) begin
        acc0 <= acc0_nxt;
        acc1 <= acc1_nxt;
        wcnt <= wcnt_base + WC_W'(1);
      end else if (clear) begin
        acc0 <= '0;
        acc1 <= '0;
        wcnt <= '0;
      end
    end
  end

`ifdef BM_SIG_HASH_EN
  logic [W-1:0] hash0, hash1, hash0_base, hash1_base, hash0_nxt, hash1_nxt;

  // Rotate-left by one then fold in the new word; written with shifts so W=1 works.
  always_comb begin
    hash0_base = clear ? '0 : hash0;
    hash1_base = clear ? '0 : hash1;
    hash0_nxt  = ((hash0_base << 1) | (hash0_base >> (W-1))) ^ y0_w;
    hash1_nxt  = ((hash1_base << 1) | (hash1_base >> (W-1))) ^ y1_w;
  end

  // Hash signatures follow the same batch boundaries as the ones counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hash0       <= '0;
      hash1       <= '0;
      sig_y0_hash <= '0;
      sig_y1_hash <= '0;
    end else if (last) begin
      sig_y0_hash <= hash0_nxt;
      sig_y1_hash <= hash1_nxt;
      hash0       <= '0;
      hash1       <= '0;
    end else if (accept) begin
      hash0 <= hash0_nxt;
      hash1 <= hash1_nxt;
    end else if (clear) begin
      hash0 <= '0;
      hash1 <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_bm_sig_sim.sv
// Bench for bm_sig_sim at W=8, BATCH=4: directed scenarios then random traffic,
// all compared against a word/batch-level reference model.
module tb_bm_sig_sim;

  localparam int W     = 8;
  localparam int BATCH = 4;
  localparam int CNT_W = $clog2(W*BATCH+1);

  logic             clk = 1'b0;
  logic             rst_n, clear, in_valid, out_ready;
  logic             in_ready, out_valid, sig_valid;
  logic [W-1:0]     in_x0, in_x1, in_x2, in_x3, out_y0, out_y1;
  logic [CNT_W-1:0] sig_y0_ones, sig_y1_ones;

  bm_sig_sim #(.W(W), .BATCH(BATCH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y0(out_y0), .out_y1(out_y1),
    .sig_valid(sig_valid), .sig_y0_ones(sig_y0_ones), .sig_y1_ones(sig_y1_ones)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: what the DUT outputs should be after the next edge.
  logic         m_ov, m_sv;
  logic [W-1:0] m_y0, m_y1;
  int           m_words, m_ones0, m_ones1, m_sig0, m_sig1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: check registered outputs, drive inputs, check in_ready, advance model.
  task automatic cyc(input logic rv, input logic iv, input logic cl, input logic orr,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] c, input logic [W-1:0] d);
    logic         exp_rdy, acc;
    logic [W-1:0] y0, y1;
    int           p0, p1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_y0", 32'(out_y0), 32'(m_y0));
    chk("out_y1", 32'(out_y1), 32'(m_y1));
    chk("sig_valid", 32'(sig_valid), 32'(m_sv));
    chk("sig_y0_ones", 32'(sig_y0_ones), 32'(m_sig0));
    chk("sig_y1_ones", 32'(sig_y1_ones), 32'(m_sig1));
    rst_n = rv; in_valid = iv; clear = cl; out_ready = orr;
    in_x0 = a; in_x1 = b; in_x2 = c; in_x3 = d;
    #1;
    exp_rdy = !m_ov || orr;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (!rv) begin
      m_ov = 0; m_sv = 0; m_y0 = '0; m_y1 = '0;
      m_sig0 = 0; m_sig1 = 0; m_words = 0; m_ones0 = 0; m_ones1 = 0;
    end else begin
      acc  = iv && exp_rdy;
      m_sv = 0;
      if (cl) begin m_words = 0; m_ones0 = 0; m_ones1 = 0; end
      if (acc) begin
        p0 = 0; p1 = 0;
        for (int i = 0; i < W; i++) begin
          y0[i] = a[i] && b[i];
          y1[i] = (c[i] && a[i]) || (b[i] && (!a[i] || d[i]));
          p0 += int'(y0[i]);
          p1 += int'(y1[i]);
        end
        m_y0 = y0; m_y1 = y1; m_ov = 1;
        m_words++; m_ones0 += p0; m_ones1 += p1;
        if (m_words == BATCH) begin
          m_sv = 1; m_sig0 = m_ones0; m_sig1 = m_ones1;
          m_words = 0; m_ones0 = 0; m_ones1 = 0;
        end
      end else if (orr) begin
        m_ov = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; clear = 0; in_valid = 0; out_ready = 0;
    in_x0 = '0; in_x1 = '0; in_x2 = '0; in_x3 = '0;
    m_ov = 0; m_sv = 0; m_y0 = '0; m_y1 = '0;
    m_sig0 = 0; m_sig1 = 0; m_words = 0; m_ones0 = 0; m_ones1 = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Reset state, then one idle cycle.
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sig_valid", 32'(sig_valid), 32'd0);
    cyc(1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single word.
    cyc(1, 1, 0, 1, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_y0", 32'(out_y0), 32'h0F);
    chk("single_y1", 32'(out_y1), 32'hF0);

    // Backpressure: accept, stall 3 cycles with a queued word, then release.
    cyc(1, 1, 0, 1, 8'h3C, 8'hFF, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 8'hAA, 8'h55, 8'h0F, 8'hF0);
    chk("bp_y0_stable", 32'(out_y0), 32'h3C);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    cyc(1, 1, 0, 1, 8'hAA, 8'h55, 8'h0F, 8'hF0);
    chk("bp_release_y0", 32'(out_y0), 32'h00);

    // Full batch from a clean start, then a 5th word back-to-back.
    cyc(1, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    chk("batch_sig_valid", 32'(sig_valid), 32'd1);
    chk("batch_y0_ones", 32'(sig_y0_ones), 32'd32);
    chk("batch_y1_ones", 32'(sig_y1_ones), 32'd0);
    cyc(1, 1, 0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    chk("batch_pulse_once", 32'(sig_valid), 32'd0);

    // Clear mid-batch: 2 words in, clear, then 4 words with y1=F0.
    cyc(1, 1, 0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    cyc(1, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    chk("clr_no_early_sig", 32'(sig_valid), 32'd0);
    chk("clr_sig_held", 32'(sig_y0_ones), 32'd32);
    cyc(1, 1, 0, 1, 8'hFF, 8'h0F, 8'hF0, 8'h00);
    chk("clr_sig_valid", 32'(sig_valid), 32'd1);
    chk("clr_y1_ones", 32'(sig_y1_ones), 32'd16);
    chk("clr_y0_ones", 32'(sig_y0_ones), 32'd16);

    // Reset mid-batch: 3 words, reset, then 4 words.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 8'h0F, 8'hFF, 8'h00, 8'h00);
    cyc(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rstmid_sig_zero", 32'(sig_y0_ones), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    chk("rstmid_no_early", 32'(sig_valid), 32'd0);
    cyc(1, 1, 0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00);
    chk("rstmid_sig_valid", 32'(sig_valid), 32'd1);
    chk("rstmid_y0_ones", 32'(sig_y0_ones), 32'd32);

    // Random traffic with occasional clear and reset.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(63) != 0), ($urandom_range(3) != 0),
          ($urandom_range(15) == 0), ($urandom_range(3) != 0),
          W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end
    cyc(1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
